// File: rtl/logic_exec_stage.sv
// logic_exec_stage: two-stage execute pipeline for the RV64 logic ops
// (XOR / OR / AND / ANDN) with valid/ready handshakes on both sides.
// S1 holds the operands, S2 holds the computed result and drives the outputs.
// Optional build macro: LOGIC_EXEC_SKID_EN adds a one-entry input skid buffer
// so that in_ready comes straight from a flop.

module logic_exec_stage #(
   parameter int XLEN = 64,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [RD_W-1:0] rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [RD_W-1:0] out_rd
);

   localparam int NLANE = XLEN / 32;

   localparam logic [1:0] OP_XOR  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_ANDN = 2'b11;

   // One 32-bit lane; ANDN arrives here as AND with b already inverted.
   function automatic logic [31:0] lane_prim(input logic [1:0] sel,
                                             input logic [31:0] la,
                                             input logic [31:0] lb);
      logic [31:0] r;
      case (sel)
         OP_XOR:  r = la ^ lb;
         OP_OR:   r = la | lb;
         default: r = la & lb;
      endcase
      return r;
   endfunction

   logic            s1_valid;
   logic [1:0]      s1_op;
   logic [XLEN-1:0] s1_a;
   logic [XLEN-1:0] s1_b;
   logic [RD_W-1:0] s1_rd;
   logic            s2_valid;

   logic            s2_adv;
   logic            s1_adv;
   logic            s1_free;
   logic            accept;
   logic            load_s1;
   logic [1:0]      src_op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [RD_W-1:0] src_rd;

   assign s2_adv  = !s2_valid || out_ready;
   assign s1_adv  = s1_valid && s2_adv;
   assign s1_free = !s1_valid || s2_adv;
   assign accept  = in_valid && in_ready;

`ifdef LOGIC_EXEC_SKID_EN
   logic            sk_valid;
   logic [1:0]      sk_op;
   logic [XLEN-1:0] sk_a;
   logic [XLEN-1:0] sk_b;
   logic [RD_W-1:0] sk_rd;

   // in_ready is a flop output: the skid slot must be free to take a new op.
   assign in_ready = !sk_valid;
   assign load_s1  = s1_free && (sk_valid || accept);
   assign src_op   = sk_valid ? sk_op : op;
   assign src_a    = sk_valid ? sk_a  : a;
   assign src_b    = sk_valid ? sk_b  : b;
   assign src_rd   = sk_valid ? sk_rd : rd;

   // Skid slot: park an accepted op S1 cannot take; drain it into S1 first.
   always_ff @(posedge clk) begin
      if (reset) begin
         sk_valid <= 1'b0;
         sk_op    <= '0;
         sk_a     <= '0;
         sk_b     <= '0;
         sk_rd    <= '0;
      end else if (accept && !s1_free) begin
         sk_valid <= 1'b1;
         sk_op    <= op;
         sk_a     <= a;
         sk_b     <= b;
         sk_rd    <= rd;
      end else if (sk_valid && s1_free) begin
         sk_valid <= 1'b0;
      end
   end
`else
   assign in_ready = s1_free;
   assign load_s1  = accept;
   assign src_op   = op;
   assign src_a    = a;
   assign src_b    = b;
   assign src_rd   = rd;
`endif

   // S1: operand register, loaded from the input (or skid slot).
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_rd    <= '0;
      end else if (load_s1) begin
         s1_valid <= 1'b1;
         s1_op    <= src_op;
         s1_a     <= src_a;
         s1_b     <= src_b;
         s1_rd    <= src_rd;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   logic [XLEN-1:0] b_eff;
   logic [XLEN-1:0] lane_res;

   assign b_eff = (s1_op == OP_ANDN) ? ~s1_b : s1_b;

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      assign lane_res[32*g +: 32] = lane_prim(s1_op, s1_a[32*g +: 32], b_eff[32*g +: 32]);
   end

   // S2: result register; holds its contents while stalled by writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         result   <= '0;
         out_rd   <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result <= lane_res;
            out_rd <= s1_rd;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule

// File: tb/tb_logic_exec_stage.sv
// Self-checking bench for logic_exec_stage: directed vector table, lane sweep,
// back-pressure, reset mid-flight and random handshake toggling.

module tb_logic_exec_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [63:0] a;
   logic [63:0] b;
   logic [4:0]  rd;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic [4:0]  out_rd;

   logic_exec_stage #(.XLEN(64), .RD_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .rd(rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_rd(out_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [63:0] exp;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  rd;
      int          cyc;
      int          lat;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[6];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit acc;

   logic        drv_reset = 1'b1;
   logic        drv_valid = 1'b0;
   logic [1:0]  drv_op    = '0;
   logic [63:0] drv_a     = '0;
   logic [63:0] drv_b     = '0;
   logic [4:0]  drv_rd    = '0;
   logic        drv_ordy  = 1'b1;
   logic [63:0] drv_exp   = '0;
   int          drv_lat   = 0;

   function automatic logic [63:0] golden(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
      case (o)
         2'b00:   return x ^ y;
         2'b01:   return x | y;
         2'b10:   return x & y;
         default: return x & ~y;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, sample 1 time unit later; the handshakes
   // seen here are the transfers that happen at the following rising edge.
   task automatic tick();
      sb_t e;
      @(negedge clk);
      reset     = drv_reset;
      in_valid  = drv_valid;
      op        = drv_op;
      a         = drv_a;
      b         = drv_b;
      rd        = drv_rd;
      out_ready = drv_ordy;
      #1;
      cyc++;
      acc = 1'b0;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got rd=%0d result=%h expected no output", out_rd, result);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("out_rd", 64'(out_rd), 64'(e.rd));
               if (e.lat != 0) chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{res: drv_exp, rd: drv_rd, cyc: cyc, lat: drv_lat});
            acc = 1'b1;
            drv_valid = 1'b0;
         end
      end
   endtask

   task automatic send(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [4:0] r, input logic [63:0] exp, input int lat);
      drv_op = o; drv_a = x; drv_b = y; drv_rd = r; drv_exp = exp; drv_lat = lat;
      drv_valid = 1'b1;
      for (int k = 0; k < 100 && drv_valid; k++) tick();
      if (drv_valid) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept for rd=%0d expected accept within 100 cycles", r);
         drv_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (sb.size() != 0 || drv_valid); k++) tick();
      checks++;
      if (sb.size() != 0 || drv_valid) begin
         errors++;
         $display("FAIL drain: got %0d entries outstanding expected 0", sb.size());
         sb.delete();
         drv_valid = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] jv[8];
      logic [63:0] ai, bj;
      int acc_n;

      vecs[0] = '{2'b00, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 5'd3, 64'hF0F00F0F_EDCBA987};
      vecs[1] = '{2'b10, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 5'd4, 64'h0F0F0000_12345678};
      vecs[2] = '{2'b01, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 5'd5, 64'hFFFF0F0F_FFFFFFFF};
      vecs[3] = '{2'b11, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 5'd6, 64'hF0F00000_00000000};
      vecs[4] = '{2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000001, 5'd7, 64'h7FFFFFFF_FFFFFFFE};
      vecs[5] = '{2'b00, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 5'd31, 64'h0};
      jv = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h81, 8'h7E};

      // Reset state
      tick(); tick();
      drv_reset = 1'b0;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_out_rd", 64'(out_rd), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed vectors streamed back to back, latency 2 each
      drv_ordy = 1'b1;
      for (int i = 0; i < 6; i++)
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 2);
      drain();

      // Lane sweep
      for (int o = 0; o < 4; o++)
         for (int i = 0; i < 256; i++)
            for (int j = 0; j < 8; j++) begin
               ai = {8{i[7:0]}};
               bj = {8{jv[j]}};
               send(o[1:0], ai, bj, 5'(i), golden(o[1:0], ai, bj), 0);
            end
      drain();

      // Back-pressure: out_ready low, three OR ops, five stalled cycles
      drv_ordy = 1'b0;
      send(2'b01, 64'h1, 64'h100, 5'd1, 64'h101, 7);
      send(2'b01, 64'h2, 64'h200, 5'd2, 64'h202, 7);
      drv_op = 2'b01; drv_a = 64'h3; drv_b = 64'h300; drv_rd = 5'd3;
      drv_exp = 64'h303; drv_lat = 0; drv_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_result", result, 64'h101);
         chk("stall_out_rd", 64'(out_rd), 64'd1);
`ifdef LOGIC_EXEC_SKID_EN
         chk("stall_in_ready", 64'(in_ready), (k == 0) ? 64'd1 : 64'd0);
`else
         chk("stall_in_ready", 64'(in_ready), 64'd0);
`endif
      end
      drv_ordy = 1'b1;
      drain();

      // Reset mid-flight: two ops in the pipe are discarded
      drv_ordy = 1'b0;
      send(2'b01, 64'hAAAA, 64'h5555, 5'd9, 64'hFFFF, 0);
      send(2'b00, 64'h1234, 64'h0001, 5'd10, 64'h1235, 0);
      drv_reset = 1'b1;
      tick();
      drv_reset = 1'b0;
      tick();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_result", result, 64'd0);
      chk("midrst_out_rd", 64'(out_rd), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      drv_ordy = 1'b1;
      for (int k = 0; k < 6; k++) tick();

      // Random valid/ready toggling
      acc_n = 0;
      for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
         if (!drv_valid && $urandom_range(3) != 0) begin
            drv_op  = 2'($urandom_range(3));
            drv_a   = {$urandom, $urandom};
            drv_b   = {$urandom, $urandom};
            drv_rd  = 5'($urandom_range(31));
            drv_exp = golden(drv_op, drv_a, drv_b);
            drv_lat = 0;
            drv_valid = 1'b1;
         end
         drv_ordy = ($urandom_range(2) != 0);
         tick();
         if (acc) acc_n++;
      end
      chk("random_accepted", 64'(acc_n), 64'd10000);
      drv_valid = 1'b0;
      drv_ordy = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
